// File: rtl/cpu_run_if.sv
// Host/memory-side signal bundle for the CPU run controller.
// The controller connects through the slave modport; the host/bench side uses master.
interface cpu_run_if #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128,
  parameter int CYCLE_W    = 32
);
  localparam int IMW = $clog2(IMEM_DEPTH + 1);
  localparam int DMW = $clog2(DMEM_DEPTH + 1);

  logic               start;
  logic [IMW-1:0]     imem_words;
  logic [DMW-1:0]     dmem_words;
  logic [CYCLE_W-1:0] run_cycles;

  logic               ld_valid;
  logic [63:0]        ld_data;
  logic               ld_ready;

  logic               dp_valid;
  logic [63:0]        dp_data;
  logic               dp_ready;

  logic               cpu_enable;
  logic [63:0]        addr_ext;
  logic               wen_ext;
  logic               ren_ext;
  logic [31:0]        wdata_ext;
  logic [63:0]        addr_ext_2;
  logic               wen_ext_2;
  logic               ren_ext_2;
  logic [63:0]        wdata_ext_2;
  logic [63:0]        rdata_ext_2;

  logic               busy;
  logic               done;

  modport master (
    output start, imem_words, dmem_words, run_cycles, ld_valid, ld_data, dp_ready, rdata_ext_2,
    input  ld_ready, dp_valid, dp_data, cpu_enable, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done
  );

  modport slave (
    input  start, imem_words, dmem_words, run_cycles, ld_valid, ld_data, dp_ready, rdata_ext_2,
    output ld_ready, dp_valid, dp_data, cpu_enable, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Load / run / dump sequencer around the CPU core's external memory ports.
//
// state    | meaning
// IDLE     | waiting for start after reset
// LOAD_I   | streaming words into instruction memory
// LOAD_D   | streaming words into data memory
// RUN      | core enabled, run-cycle down-counter active
// DUMP_RD  | issue data-memory read
// DUMP_CAP | capture read data into dump register
// DUMP_OUT | offer dump word until consumer accepts
// DONE     | sequence complete, waiting for next start
module cpu_run_controller #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128,
  parameter int CYCLE_W    = 32
) (
  input  logic     clk,
  input  logic     arst_n,
  cpu_run_if.slave bus
);
  localparam int IMW   = $clog2(IMEM_DEPTH + 1);
  localparam int DMW   = $clog2(DMEM_DEPTH + 1);
  localparam int IDX_W = (IMW > DMW) ? IMW : DMW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_I   = 3'd1;
  localparam logic [2:0] S_LOAD_D   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DUMP_RD  = 3'd4;
  localparam logic [2:0] S_DUMP_CAP = 3'd5;
  localparam logic [2:0] S_DUMP_OUT = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [2:0]         state, state_nxt;
  logic [IDX_W-1:0]   idx, imem_n, dmem_n, word_lim;
  logic [IDX_W-1:0]   imem_sat, dmem_sat;
  logic [CYCLE_W-1:0] run_cnt;
  logic [63:0]        dp_data_q;
  logic               cpu_en_q;
  logic               last_word;
  logic [2:0]         first_phase;

  assign imem_sat = (bus.imem_words > IMW'(IMEM_DEPTH)) ? IDX_W'(IMEM_DEPTH) : IDX_W'(bus.imem_words);
  assign dmem_sat = (bus.dmem_words > DMW'(DMEM_DEPTH)) ? IDX_W'(DMEM_DEPTH) : IDX_W'(bus.dmem_words);

  assign first_phase = (imem_sat != '0)       ? S_LOAD_I :
                       (dmem_sat != '0)       ? S_LOAD_D :
                       (bus.run_cycles != '0) ? S_RUN    : S_DONE;

  assign word_lim  = (state == S_LOAD_I) ? imem_n : dmem_n;
  assign last_word = (idx == word_lim - ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = first_phase;
      S_LOAD_I: if (bus.ld_valid && last_word)
                  state_nxt = (dmem_n != '0) ? S_LOAD_D : (run_cnt != '0) ? S_RUN : S_DONE;
      S_LOAD_D: if (bus.ld_valid && last_word)
                  state_nxt = (run_cnt != '0) ? S_RUN : S_DUMP_RD;
      S_RUN: if (run_cnt == CYCLE_W'(1))
               state_nxt = (dmem_n != '0) ? S_DUMP_RD : S_DONE;
      S_DUMP_RD:  state_nxt = S_DUMP_CAP;
      S_DUMP_CAP: state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: if (bus.dp_ready) state_nxt = last_word ? S_DONE : S_DUMP_RD;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // cpu_enable comes straight from a flop so it cannot glitch on state decode
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      imem_n    <= '0;
      dmem_n    <= '0;
      run_cnt   <= '0;
      dp_data_q <= '0;
      cpu_en_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cpu_en_q <= (state_nxt == S_RUN);
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          imem_n  <= imem_sat;
          dmem_n  <= dmem_sat;
          run_cnt <= bus.run_cycles;
          idx     <= '0;
        end
        S_LOAD_I, S_LOAD_D: if (bus.ld_valid) idx <= last_word ? '0 : idx + ONE;
        S_RUN:      run_cnt <= run_cnt - CYCLE_W'(1);
        S_DUMP_CAP: dp_data_q <= bus.rdata_ext_2;
        S_DUMP_OUT: if (bus.dp_ready && !last_word) idx <= idx + ONE;
        default: ;
      endcase
    end
  end

  assign bus.ld_ready    = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign bus.wen_ext     = (state == S_LOAD_I) && bus.ld_valid;
  assign bus.addr_ext    = bus.wen_ext ? (64'(idx) << 2) : 64'd0;
  assign bus.wdata_ext   = bus.wen_ext ? bus.ld_data[31:0] : 32'd0;
  assign bus.ren_ext     = 1'b0;
  assign bus.wen_ext_2   = (state == S_LOAD_D) && bus.ld_valid;
  assign bus.ren_ext_2   = (state == S_DUMP_RD);
  assign bus.addr_ext_2  = (bus.wen_ext_2 || bus.ren_ext_2) ? (64'(idx) << 3) : 64'd0;
  assign bus.wdata_ext_2 = bus.wen_ext_2 ? bus.ld_data : 64'd0;
  assign bus.cpu_enable  = cpu_en_q;
  assign bus.dp_valid    = (state == S_DUMP_OUT);
  assign bus.dp_data     = dp_data_q;
  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done        = (state == S_DONE);
endmodule
